sevenseg_scanner: RTL
=====================

// Module: sevenseg_scanner
// PURPOSE
// - Output-side user interface: drives the time-multiplexed 4-digit common-anode 7-segment display.
// - Complements the pushbutton input path. Game logic supplies 4 hex nibbles plus per-digit dp/blank/blink.
// - The block scans the digits, decodes each nibble, inserts an anti-ghosting guard gap,
//   and blinks the digits that are flagged to blink.
// PARAMETERS
// - DIGIT_CYCLES  100000    clk cycles per digit slot (1 ms at 100 MHz); legal range >= 4.
// - GUARD_CYCLES  2000      dark cycles at the start of each slot (all anodes off); legal range 1..DIGIT_CYCLES-2.
// - BLINK_CYCLES  25000000  clk cycles per blink half-period (0.25 s at 100 MHz); legal range >= 2.
// PORTS
// - clk      in   1   system clock
// - reset    in   1   synchronous, active-high reset
// - digits   in   16  hex values; digits[4i+3:4i] shows on digit i (i=0 is the rightmost digit)
// - dp_in    in   4   decimal point request per digit, active-high
// - blank    in   4   per-digit force-dark, active-high
// - blink    in   4   per-digit blink enable, active-high
// - an       out  4   anode enables, active-low; an[i] drives digit i
// - seg      out  7   cathodes, active-low, {g,f,e,d,c,b,a} = seg[6:0]
// - dp       out  1   decimal-point cathode, active-low
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset: slot_cnt=0, idx=0, blink_cnt=0, blink_ph=0, latched data=0, an=4'hF, seg=7'h7F, dp=1.
// - slot_cnt runs 0..DIGIT_CYCLES-1 and wraps to 0.
//   - On the wrap, idx advances 0->1->2->3->0.
// - Latch: in the cycle where slot_cnt==0, register digits[4idx+:4], dp_in[idx], blank[idx] and blink[idx]
//   for the new idx.
//   - Input changes at any other time are invisible until the next slot's latch.
// - blink_cnt runs 0..BLINK_CYCLES-1; on wrap, blink_ph toggles.
//   - blink_cnt is free-running and independent of the scan.
// - Digit is lit when slot_cnt>=GUARD_CYCLES AND blank_l==0 AND NOT (blink_l==1 AND blink_ph==1).
// - Outputs are registered with one cycle of latency from slot_cnt and blink_ph.
//   - Lit:  an=~(4'b0001<<idx), seg=decode(nib_l), dp=~dp_l.
//   - Dark: an=4'hF, seg=7'h7F, dp=1. Never leave an low with stale seg.
//   - an has at most one bit low in any cycle.
// - Decode table, 0..F (hex):
//   40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E  (A,b,C,d,E,F glyphs).
// - Timing: for a slot whose slot_cnt==0 at cycle T, an goes low at T+GUARD_CYCLES+1
//   and returns high at T+DIGIT_CYCLES+1.
// - Boundary and simultaneous events:
//   - Slot wrap and blink wrap in the same cycle: both take effect; there is no priority issue.
//   - blink_ph changes mid-slot: it takes effect immediately, with the 1-cycle output latency.
//   - All four digits blanked: an stays 4'hF permanently; the scan keeps running.
// - Reset mid-slot: the cycle after reset is sampled, outputs are dark and idx=0.
//   - After reset deasserts, the first slot is digit 0, with a full guard period.
// TESTING (DIGIT_CYCLES=8, GUARD_CYCLES=2, BLINK_CYCLES=64)
// 1. Reset with digits=16'h1234, no flags, then release ->
//    - an=4'hF for cycles 1-2, then 4'b1110 with seg=7'h19 ('4') for cycles 3-8.
//    - Then 4'b1101 with seg=7'h30 ('3'), and so on; the scan order is 0,1,2,3,0.
// 2. Sweep digits[3:0] through 0..F on slot boundaries -> seg on digit 0 matches the decode table, every value.
// 3. dp_in=4'b0100 and blank=4'b0010 ->
//    - dp=0 only while an=4'b1011.
//    - an never equals 4'b1101; digit 1's slot stays fully dark.
// 4. blink=4'b0001 ->
//    - digit 0 is lit during blink_ph=0 half-periods and dark (an=4'hF) during blink_ph=1.
//    - Other digits are unaffected.
// 5. Change digits[3:0] from 5 to 9 at slot_cnt==4 of digit 0's slot ->
//    - seg stays 7'h12 to the end of that slot.
//    - 7'h10 appears in digit 0's next slot.
// 6. Assert reset at slot_cnt==5 of digit 2 ->
//    - next cycle an=4'hF, seg=7'h7F, dp=1.
//    - After release, digit 0 lights after the 2-cycle guard gap.
// - All tests: assertion that an is never low during the first GUARD_CYCLES+1 cycles of any slot,
//   and an is never multi-hot.

Source files
------------

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with
// per-digit blank/blink/decimal point and a dark guard gap at the start of each slot.
module sevenseg_scanner #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 2000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    input  logic [3:0]  blink,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SLOT_W  = $clog2(DIGIT_CYCLES);
    localparam int BLINK_W = $clog2(BLINK_CYCLES);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  GUARD_L    = SLOT_W'(GUARD_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [SLOT_W-1:0]  r_slot_cnt;
    logic [1:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_ph;
    logic [3:0]         r_nib_l;
    logic               r_dp_l;
    logic               r_blank_l;
    logic               r_blink_l;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_slot_wrap;
    logic               w_blink_wrap;
    logic [3:0]         w_nib_sel;
    logic               w_lit;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
    assign w_nib_sel    = digits[{r_idx, 2'b00} +: 4];

    // The guard term also hides the stale latch during slot_cnt==0, when the
    // new digit's data is only being captured.
    always_comb begin
        w_lit = 1'b0;
        if ((r_slot_cnt >= GUARD_L) && !r_blank_l && !(r_blink_l && r_blink_ph)) begin
            w_lit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt  <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_nib_l     <= '0;
            r_dp_l      <= 1'b0;
            r_blank_l   <= 1'b0;
            r_blink_l   <= 1'b0;
            r_an        <= 4'hF;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
        end else begin
            r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + SLOT_W'(1);
            if (w_slot_wrap) begin
                r_idx <= r_idx + 2'd1;
            end

            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLINK_W'(1);
            if (w_blink_wrap) begin
                r_blink_ph <= ~r_blink_ph;
            end

            if (r_slot_cnt == '0) begin
                r_nib_l   <= w_nib_sel;
                r_dp_l    <= dp_in[r_idx];
                r_blank_l <= blank[r_idx];
                r_blink_l <= blink[r_idx];
            end

            // Anode and cathodes always update together so a lit anode never sees stale segments.
            if (w_lit) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= decode(r_nib_l);
                r_dp  <= ~r_dp_l;
            end else begin
                r_an  <= 4'hF;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
